// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM read port, decoded-instruction handshake toward execute,
// and the committed next-IP return path.
interface inst_fetch_if;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       inst_valid;
    logic       inst_ready;
    logic [3:0] opecode;
    logic [3:0] imm;
    logic       illegal;
    logic [3:0] next_ip;
    logic       next_ip_valid;

    modport master (
        output rom_en, rom_addr, inst_valid, opecode, imm, illegal,
        input  rom_data, inst_ready, next_ip, next_ip_valid
    );

    modport slave (
        input  rom_en, rom_addr, inst_valid, opecode, imm, illegal,
        output rom_data, inst_ready, next_ip, next_ip_valid
    );
endinterface

// File: rtl/inst_fetch.sv
// Fetch/decode stage: tick-paced ROM fetch, opecode/imm split, valid/ready to execute.
// Optional single-step gating of fetch issue is enabled with `define STEP_INST_EN.
module inst_fetch #(
    parameter int CLK_DIV = 1,
    parameter int ROM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    inst_fetch_if.master bus
);

    typedef enum logic [3:0] {
        ADD_A_IMM = 4'h0, MOV_A_B   = 4'h1, IN_A      = 4'h2, MOV_A_IMM = 4'h3,
        MOV_B_A   = 4'h4, ADD_B_IMM = 4'h5, IN_B      = 4'h6, MOV_B_IMM = 4'h7,
        OUT_B     = 4'h9, OUT_IMM   = 4'hB, JNC_IMM   = 4'hE, JMP_IMM   = 4'hF
    } opecode_e;

    typedef enum logic [2:0] {WAIT_TICK, ISSUE, WAIT_ROM, HOLD, WAIT_IP} state_e;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lat_q, lat_d;
    logic [3:0]       ip_q, ip_d;
    logic [3:0]       opc_q, opc_d;
    logic [3:0]       imm_q, imm_d;
    logic             ill_q, ill_d;
    logic             tick;
    logic             go;
    logic             raw_illegal;

    assign tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

`ifdef STEP_INST_EN
    // sync_q[1:0] is the synchronizer, sync_q[2] the previous synchronized level.
    logic [2:0] sync_q, sync_d;
    logic       pend_q, pend_d;

    assign go = tick && pend_q;

    always_comb begin
        sync_d = {sync_q[1], sync_q[0], step};
        pend_d = pend_q || (sync_q[1] && !sync_q[2]);
        if (state_q == WAIT_TICK && go) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            pend_q <= pend_d;
        end
    end
`else
    logic unused_step;
    assign unused_step = step;
    assign go          = tick;
`endif

    always_comb begin
        case (bus.rom_data[7:4])
            ADD_A_IMM, MOV_A_B, IN_A, MOV_A_IMM, MOV_B_A, ADD_B_IMM,
            IN_B, MOV_B_IMM, OUT_B, OUT_IMM, JNC_IMM, JMP_IMM: raw_illegal = 1'b0;
            default:                                           raw_illegal = 1'b1;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        ip_d    = ip_q;
        opc_d   = opc_q;
        imm_d   = imm_q;
        ill_d   = ill_q;
        case (state_q)
            WAIT_TICK: if (go) state_d = ISSUE;
            ISSUE: begin
                lat_d   = 2'd1;
                state_d = WAIT_ROM;
            end
            WAIT_ROM: begin
                if (lat_q == 2'(ROM_LAT)) begin
                    opc_d   = bus.rom_data[7:4];
                    imm_d   = bus.rom_data[3:0];
                    ill_d   = raw_illegal;
                    state_d = HOLD;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            HOLD:    if (bus.inst_ready) state_d = WAIT_IP;
            WAIT_IP: begin
                if (bus.next_ip_valid) begin
                    ip_d    = bus.next_ip;
                    state_d = WAIT_TICK;
                end
            end
            default: state_d = WAIT_TICK;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_TICK;
            cnt_q   <= '0;
            lat_q   <= '0;
            ip_q    <= '0;
            opc_q   <= '0;
            imm_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            ip_q    <= ip_d;
            opc_q   <= opc_d;
            imm_q   <= imm_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.rom_en     = (state_q == ISSUE);
    assign bus.rom_addr   = ip_q;
    assign bus.inst_valid = (state_q == HOLD);
    assign bus.opecode    = opc_q;
    assign bus.imm        = imm_q;
    assign bus.illegal    = ill_q;

endmodule
